// File: rtl/median_pkg.sv
// Shared constants and FSM state type for the median filter driver.
package median_pkg;

  localparam int NUM_TAPS        = 9;
  localparam int DEFAULT_TIMEOUT = 63;

  localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } drv_state_e;

endpackage

// File: rtl/median_drv_tmr.sv
// WAIT-state watchdog: counts cycles while run_i is high and flags the last allowed one.
// Only instantiated when MEDIAN_DRV_TIMEOUT_EN is defined.
module median_drv_tmr
  import median_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic CLK,
  input  logic RST,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter restarts every time the driver re-enters WAIT.
  always_comb begin
    cnt_d = run_i ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/median_driver.sv
// Serialises a 9-pixel window into a median filter and captures its result.
// Optional WAIT timeout with sticky ERR is enabled by defining MEDIAN_DRV_TIMEOUT_EN.
module median_driver
  import median_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           WIN_VALID,
  output logic                           WIN_READY,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] WIN_DATA,
  output logic                           DSI,
  output logic [DATA_WIDTH-1:0]          DI,
  input  logic                           DSO,
  input  logic [DATA_WIDTH-1:0]          DO,
  output logic                           RES_VALID,
  input  logic                           RES_READY,
  output logic [DATA_WIDTH-1:0]          RES_DATA,
  output logic                           ERR
);

  drv_state_e            state_q, state_d;
  logic [3:0]            tap_q, tap_d;
  logic                  dsi_q, dsi_d;
  logic [DATA_WIDTH-1:0] di_q, di_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] pix_q [NUM_TAPS];
  logic                  capture;
  logic                  timeout;

`ifdef MEDIAN_DRV_TIMEOUT_EN
  logic err_q;

  median_drv_tmr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmr (
    .CLK      (CLK),
    .RST      (RST),
    .run_i    (state_q == ST_WAIT),
    .expire_o (timeout)
  );

  // A result arriving on the expiry cycle takes priority over the abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  err_q <= 1'b0;
    else if (timeout && !DSO) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    dsi_d   = dsi_q;
    di_d    = di_q;
    res_d   = res_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (WIN_VALID) begin
          capture = 1'b1;
          tap_d   = '0;
          dsi_d   = 1'b1;
          di_d    = WIN_DATA[0 +: DATA_WIDTH];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // tap_q is the index of the pixel currently on DI.
        if (tap_q == LAST_TAP) begin
          dsi_d   = 1'b0;
          state_d = ST_WAIT;
        end else begin
          tap_d = tap_q + 4'd1;
          di_d  = pix_q[tap_q + 4'd1];
        end
      end
      ST_WAIT: begin
        if (DSO) begin
          res_d   = DO;
          state_d = ST_HOLD;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (RES_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      dsi_q   <= 1'b0;
      di_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      dsi_q   <= dsi_d;
      di_q    <= di_d;
      res_q   <= res_d;
    end
  end

  // NOTE: the window store is not reset; it is only read after a capture has filled it.
  always_ff @(posedge CLK) begin
    if (capture) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        pix_q[k] <= WIN_DATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign WIN_READY = (state_q == ST_IDLE);
  assign RES_VALID = (state_q == ST_HOLD);
  assign DSI       = dsi_q;
  assign DI        = di_q;
  assign RES_DATA  = res_q;

endmodule
